// File: rtl/systolic_pkg.sv
// systolic_pkg: types and helpers shared by the systolic array datapath blocks.
// Rev 1.0
`default_nettype none

package systolic_pkg;

   localparam int PKG_COLS      = 4;
   localparam int PKG_WORD_SIZE = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } out_wr_state_t;

   typedef logic [PKG_COLS*PKG_WORD_SIZE-1:0] row_word_t;
   typedef logic [PKG_WORD_SIZE-1:0]          elem_t;

   function automatic elem_t col_sel_f(input row_word_t bus, input int unsigned c);
      return bus[c*PKG_WORD_SIZE +: PKG_WORD_SIZE];
   endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_output_writer_if.sv
// matmul_output_writer_if: array result inputs, BRAM write port and status of the output writer.
// Rev 1.0
`default_nettype none

interface matmul_output_writer_if #(
   parameter int COLS           = 4,
   parameter int WORD_SIZE      = 16,
   parameter int MEM_PORT_WIDTH = COLS*WORD_SIZE
);
   logic                        start;
   logic [COLS*WORD_SIZE-1:0]   bottom_out_bus;
   logic [COLS-1:0]             output_col_valid;
   logic [COLS*WORD_SIZE-1:0]   proxy_output_bus;
   logic [COLS-1:0]             proxy_out_valid_bus;
   logic                        mem_wr_en;
   logic [31:0]                 mem_addr;
   logic [MEM_PORT_WIDTH-1:0]   mem_wr_data;
   logic                        busy;
   logic                        done;
   logic                        overflow;

   modport master (
      output start, bottom_out_bus, output_col_valid, proxy_output_bus, proxy_out_valid_bus,
      input  mem_wr_en, mem_addr, mem_wr_data, busy, done, overflow
   );

   modport slave (
      input  start, bottom_out_bus, output_col_valid, proxy_output_bus, proxy_out_valid_bus,
      output mem_wr_en, mem_addr, mem_wr_data, busy, done, overflow
   );
endinterface

`default_nettype wire

// File: rtl/out_col_capture.sv
// out_col_capture: one column's proxy/array select, result counter, overflow detect and row buffer.
// Rev 1.0
`default_nettype none

module out_col_capture #(
   parameter int ROWS      = 4,
   parameter int WORD_SIZE = 16,
   parameter int CNT_W     = $clog2(ROWS+1),
   parameter int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 i_clear,
   input  wire logic                 i_capture_en,
   input  wire logic [WORD_SIZE-1:0] i_arr_data,
   input  wire logic                 i_arr_valid,
   input  wire logic [WORD_SIZE-1:0] i_prx_data,
   input  wire logic                 i_prx_valid,
   input  wire logic [ROW_W-1:0]     i_rd_row,
   output logic      [CNT_W-1:0]     o_cnt_next,
   output logic      [WORD_SIZE-1:0] o_rd_data_next,
   output logic                      o_ovf_hit
);
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WORD_SIZE-1:0] buf_q [ROWS];
   logic [WORD_SIZE-1:0] buf_d [ROWS];
   logic                 w_valid;
   logic [WORD_SIZE-1:0] w_data;

   always_comb begin
      w_valid   = i_prx_valid | i_arr_valid;
      w_data    = i_prx_valid ? i_prx_data : i_arr_data;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      o_ovf_hit = 1'b0;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_capture_en && w_valid) begin
         if (cnt_q == CNT_W'(ROWS)) begin
            o_ovf_hit = 1'b1;
         end else begin
            buf_d[cnt_q[ROW_W-1:0]] = w_data;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Next-state views let the row commit see a column captured on this same edge.
   assign o_cnt_next     = cnt_d;
   assign o_rd_data_next = buf_d[i_rd_row];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

endmodule

`default_nettype wire

// File: rtl/matmul_output_writer.sv
// matmul_output_writer: reassembles skewed column results into rows and writes them to BRAM.
// Rev 1.0
`default_nettype none

module matmul_output_writer
   import systolic_pkg::*;
#(
   parameter int          ROWS           = 4,
   parameter int          COLS           = 4,
   parameter int          WORD_SIZE      = 16,
   parameter int          MEM_PORT_WIDTH = COLS*WORD_SIZE,
   parameter logic [31:0] BASE_ADDR      = 32'd0
) (
   input wire logic               clk,
   input wire logic               rst,
   matmul_output_writer_if.slave  bus
);
   localparam int CNT_W = $clog2(ROWS+1);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   out_wr_state_t             state_q, state_d;
   logic [CNT_W-1:0]          wr_row_q, wr_row_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      overflow_q, overflow_d;
   logic                      wr_en_q, wr_en_d;
   logic [31:0]               addr_q, addr_d;
   logic [MEM_PORT_WIDTH-1:0] data_q, data_d;

   logic                      w_clear;
   logic                      w_cap_en;
   logic                      w_row_ready;
   logic [CNT_W-1:0]          w_cnt_next [COLS];
   logic [COLS*WORD_SIZE-1:0] w_row_data;
   logic [COLS-1:0]           w_ovf_hit;

   assign w_clear  = (state_q == ST_IDLE) && bus.start;
   assign w_cap_en = (state_q == ST_COLLECT);

   for (genvar gi = 0; gi < COLS; gi++) begin : g_col
      out_col_capture #(
         .ROWS      (ROWS),
         .WORD_SIZE (WORD_SIZE),
         .CNT_W     (CNT_W),
         .ROW_W     (ROW_W)
      ) u_cap (
         .clk            (clk),
         .rst            (rst),
         .i_clear        (w_clear),
         .i_capture_en   (w_cap_en),
         .i_arr_data     (bus.bottom_out_bus[gi*WORD_SIZE +: WORD_SIZE]),
         .i_arr_valid    (bus.output_col_valid[gi]),
         .i_prx_data     (bus.proxy_output_bus[gi*WORD_SIZE +: WORD_SIZE]),
         .i_prx_valid    (bus.proxy_out_valid_bus[gi]),
         .i_rd_row       (wr_row_q[ROW_W-1:0]),
         .o_cnt_next     (w_cnt_next[gi]),
         .o_rd_data_next (w_row_data[gi*WORD_SIZE +: WORD_SIZE]),
         .o_ovf_hit      (w_ovf_hit[gi])
      );
   end

   always_comb begin
      w_row_ready = (wr_row_q < CNT_W'(ROWS));
      for (int c = 0; c < COLS; c++) begin
         if (w_cnt_next[c] <= wr_row_q) w_row_ready = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_row_d   = wr_row_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      overflow_d = overflow_q;
      wr_en_d    = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d    = ST_COLLECT;
               wr_row_d   = '0;
               overflow_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ST_COLLECT: begin
            if (|w_ovf_hit) overflow_d = 1'b1;
            // wr_row reaching ROWS means the final row's write is on the port this cycle.
            if (wr_row_q == CNT_W'(ROWS)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (w_row_ready) begin
               wr_en_d  = 1'b1;
               addr_d   = BASE_ADDR + 32'(wr_row_q);
               data_d   = w_row_data;
               wr_row_d = wr_row_q + CNT_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_row_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         wr_en_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         wr_row_q   <= wr_row_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
         wr_en_q    <= wr_en_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   assign bus.mem_wr_en   = wr_en_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wr_data = data_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_matmul_output_writer.sv
// tb_matmul_output_writer: table of matmul scenarios checked through a write scoreboard.
// Rev 1.0
`default_nettype none

module tb_matmul_output_writer;
   import systolic_pkg::*;

   localparam int          ROWS = 4;
   localparam int          COLS = 4;
   localparam int          WS   = 16;
   localparam logic [31:0] BASE = 32'd0;

   typedef logic [3:0][15:0] lrow_t;

   typedef struct {
      bit                     skewed;
      int                     proxy_col;
      bit                     extra;
      int                     start_k;
      logic [3:0][3:0][15:0]  left;
      logic [63:0]            exp_row0;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
      int          cyc;
   } sb_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_pass;
   int   wr_cnt;
   int   done_cnt;
   logic [63:0] row0_data;
   sb_t  sb [$];
   vec_t vecs [5];
   int   top_m [4][4] = '{'{5,0,0,1}, '{4,8,6,2}, '{1,21,9,3}, '{6,7,1,1}};

   matmul_output_writer_if #(.COLS(COLS), .WORD_SIZE(WS), .MEM_PORT_WIDTH(COLS*WS)) ifc ();

   matmul_output_writer #(
      .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .MEM_PORT_WIDTH(COLS*WS), .BASE_ADDR(BASE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic lrow_t mkrow(input int a, input int b, input int c, input int d);
      lrow_t r;
      r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
      return r;
   endfunction

   function automatic logic [63:0] model_row(input vec_t v, input int r);
      logic [63:0] w;
      int s;
      w = '0;
      for (int c = 0; c < COLS; c++) begin
         s = 0;
         for (int k = 0; k < 4; k++) s += int'(v.left[r][k]) * top_m[k][c];
         w[c*WS +: WS] = s[15:0];
      end
      return w;
   endfunction

   // Write monitor: every write must match the head of the scoreboard, including its cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (ifc.mem_wr_en) begin
            wr_cnt++;
            if (ifc.mem_addr == BASE) row0_data = ifc.mem_wr_data;
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_write: addr %0d data 0x%0h with empty scoreboard", ifc.mem_addr, ifc.mem_wr_data);
            end else begin
               sb_t e;
               e = sb.pop_front();
               chk("wr_addr",  ifc.mem_addr,    e.addr);
               chk("wr_data",  ifc.mem_wr_data, e.data);
               chk("wr_cycle", cyc,             e.cyc);
            end
         end
         if (ifc.done) done_cnt++;
      end
   end

   task automatic clear_inputs();
      ifc.start               = 1'b0;
      ifc.bottom_out_bus      = '0;
      ifc.output_col_valid    = '0;
      ifc.proxy_output_bus    = '0;
      ifc.proxy_out_valid_bus = '0;
   endtask

   task automatic push_exp(input vec_t v, input int t0);
      sb_t e;
      for (int r = 0; r < ROWS; r++) begin
         e.addr = BASE + 32'(r);
         e.data = model_row(v, r);
         e.cyc  = t0 + (v.skewed ? COLS : 1) + r;
         sb.push_back(e);
      end
   endtask

   task automatic drive_stream(input vec_t v, input int stop_k);
      int          nk;
      int          r;
      logic [63:0] bob, prb;
      logic [3:0]  ov, pv;
      row_word_t   rw;
      nk = v.skewed ? (ROWS + COLS - 1) : ROWS;
      if (v.extra && nk < ROWS + 1) nk = ROWS + 1;
      for (int k = 0; k < nk && k < stop_k; k++) begin
         bob = '0; prb = '0; ov = '0; pv = '0;
         for (int c = 0; c < COLS; c++) begin
            r = v.skewed ? (k - c) : k;
            if (r >= 0 && r < ROWS) begin
               rw = model_row(v, r);
               if (c == v.proxy_col) begin
                  bob[c*WS +: WS] = 16'hDEAD;
                  prb[c*WS +: WS] = col_sel_f(rw, c);
                  pv[c] = 1'b1;
               end else begin
                  bob[c*WS +: WS] = col_sel_f(rw, c);
               end
               ov[c] = 1'b1;
            end
         end
         if (v.extra && k == ROWS) begin
            bob[0 +: WS] = 16'hBEEF;
            ov[0] = 1'b1;
         end
         ifc.start               = (k == v.start_k);
         ifc.bottom_out_bus      = bob;
         ifc.output_col_valid    = ov;
         ifc.proxy_output_bus    = prb;
         ifc.proxy_out_valid_bus = pv;
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   task automatic wait_done(input int lastw);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (ifc.done) got = 1'b1;
      end
      chk("done_seen", got, 1);
      if (got) begin
         chk("done_cycle", cyc, lastw + 1);
         chk("busy_low_at_done", ifc.busy, 0);
         @(negedge clk);
         chk("done_one_cycle", ifc.done, 0);
      end
   endtask

   task automatic run_vec(input vec_t v, input bit prev_ovf);
      int t0;
      int snap_done;
      snap_done = done_cnt;
      row0_data = '0;
      @(posedge clk); #1;
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      chk("busy_rise", ifc.busy, 1);
      if (prev_ovf) chk("ovf_cleared_by_start", ifc.overflow, 0);
      t0 = cyc;
      push_exp(v, t0);
      drive_stream(v, 100);
      wait_done(t0 + (v.skewed ? COLS : 1) + ROWS - 1);
      chk("row0_table",    row0_data,     v.exp_row0);
      chk("overflow_flag", ifc.overflow,  64'(v.extra));
      chk("sb_drained",    sb.size(),     0);
      chk("done_count",    done_cnt - snap_done, 1);
   endtask

   initial begin
      int t0;
      int wr_snap;
      cyc = 0; n_chk = 0; n_pass = 0; wr_cnt = 0; done_cnt = 0;
      rst = 1'b1;
      clear_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_en",    ifc.mem_wr_en,   0);
      chk("rst_addr",     ifc.mem_addr,    0);
      chk("rst_data",     ifc.mem_wr_data, 0);
      chk("rst_busy",     ifc.busy,        0);
      chk("rst_done",     ifc.done,        0);
      chk("rst_overflow", ifc.overflow,    0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         vecs[i].skewed    = 1'b1;
         vecs[i].proxy_col = -1;
         vecs[i].extra     = 1'b0;
         vecs[i].start_k   = -1;
         vecs[i].left[1]   = mkrow(3, 1, 0, 2);
         vecs[i].left[2]   = mkrow(1, 1, 1, 1);
         vecs[i].left[3]   = mkrow(0, 2, 5, 7);
      end
      vecs[0].left[0] = mkrow(9, 4, 2, 1); vecs[0].exp_row0 = {16'd24, 16'd43, 16'd81, 16'd69};
      vecs[1].left[0] = mkrow(9, 4, 2, 1); vecs[1].exp_row0 = {16'd24, 16'd43, 16'd81, 16'd69};
      vecs[1].proxy_col = 2;
      vecs[2].left[0] = mkrow(2, 1, 0, 0); vecs[2].exp_row0 = {16'd4, 16'd6, 16'd8, 16'd14};
      vecs[2].skewed  = 1'b0;
      vecs[3].left[0] = mkrow(1, 1, 1, 1); vecs[3].exp_row0 = {16'd7, 16'd16, 16'd36, 16'd16};
      vecs[3].extra   = 1'b1;
      vecs[4].left[0] = mkrow(0, 0, 0, 1); vecs[4].exp_row0 = {16'd1, 16'd1, 16'd7, 16'd6};
      vecs[4].start_k = 6;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], (i > 0) ? vecs[i-1].extra : 1'b0);

      // Reset after row 1 has been written, while row 2 is on the port.
      @(posedge clk); #1;
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      t0 = cyc;
      push_exp(vecs[0], t0);
      drive_stream(vecs[0], 6);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_wr_en",    ifc.mem_wr_en,   0);
      chk("mid_rst_addr",     ifc.mem_addr,    0);
      chk("mid_rst_data",     ifc.mem_wr_data, 0);
      chk("mid_rst_busy",     ifc.busy,        0);
      chk("mid_rst_done",     ifc.done,        0);
      chk("mid_rst_overflow", ifc.overflow,    0);
      chk("rows_before_rst",  4 - sb.size(),   2);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      wr_snap = wr_cnt;
      drive_stream(vecs[0], 100);
      repeat (5) @(negedge clk);
      chk("no_write_without_start", wr_cnt, wr_snap);
      chk("idle_after_rst_busy",    ifc.busy, 0);
      run_vec(vecs[0], 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
